fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller that consumes the pipeline stall handshake (`stall`, `stall_pm`) and acts on it. It owns the program counter and the fetch instruction register, and drives the opcode field back to the stall generator. It freezes fetch on `stall`, injects a NOP bubble on the delayed `stall_pm`, and redirects the PC on jumps. It latches the halted state and also keeps a stall-cycle counter and a handshake-protocol error flag.

## Interface
- `AW`, 8: program-memory address width (PC width).
- `DW`, 32: instruction width; opcode is `ir[DW-1:DW-6]`.
- `CNT_W`, 16: stall counter width.

- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- `stall`  in  1  stall request from the stall generator.
- `stall_pm`  in  1  `stall` delayed one cycle; program-memory gate.
- `jump_target`  in  AW  jump destination, valid while a JUMP opcode is in `ir`.
- `pm_data`  in  DW  program-memory read data for `pm_addr` (combinational read).
- `pm_addr`  out  AW  equals `pc`.
- `ir`  out  DW  fetched instruction to decode.
- `op`  out  6 [0:5]  `op[0]=ir[DW-1]` … `op[5]=ir[DW-6]`, fed to the stall generator.
- `halted`  out  1  high in HALTED state.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall`=1.
- `proto_err`  out  1  sticky handshake-violation flag.

## Operation
- Opcodes are written as bit strings `op[0]..op[5]`:
  - HLT = 010001.
  - LD1 = 010100.
  - JUMP = 0111xx.
  - NOP = ir all-zero.
- The FSM has three states: RUN, JUMP_WAIT and HALTED.
- Per-cycle action in RUN and JUMP_WAIT, in priority order:
  - `stall`=1: `pc` holds and `ir` holds. The frozen opcode keeps driving `op`.
  - `stall`=0, `stall_pm`=1: `ir` <= NOP (bubble).
    - In RUN, `pc` holds.
    - In JUMP_WAIT, `pc` <= latched target and the state goes to RUN.
  - `stall`=0, `stall_pm`=0: `ir` <= `pm_data`, `pc` <= `pc`+1.
    - In JUMP_WAIT (`stall_pm` was already low), `pc` <= target+1 and `ir` <= `pm_data`. This case is legal but not produced by a well-formed generator.
- RUN -> JUMP_WAIT when `stall`=1 and `op` matches JUMP. `jump_target` is latched into an internal AW-bit register on that edge only. Further JUMP stall cycles do not relatch.
- RUN or JUMP_WAIT -> HALTED when `stall`=1 and `op`==HLT. In HALTED:
  - `pc` and `ir` are frozen.
  - `halted`=1.
  - Only reset exits HALTED.
- `pc` wraps from 2^AW-1 to 0 with no flag.
- `stall_cnt` increments on every cycle with `stall`=1, including HALTED. It saturates at all-ones and never wraps.
- `proto_err` protocol check:
  - A shadow register holds `stall` from the previous cycle; it is 0 after reset.
  - `proto_err` sets when `stall_pm` != shadow.
  - Once set, it stays set until reset.
  - Checking continues in HALTED.

## Timing
- Reset values (reset==0 at an edge):
  - `pc`=0, `ir`=0 (NOP), `op`=000000.
  - State RUN, `halted`=0, `stall_cnt`=0, `proto_err`=0.
  - Jump-target register=0, stall shadow=0.
- Reset has priority over every other event, including HLT and an in-progress JUMP_WAIT.
- The first fetch happens on the first edge with reset==1 and `stall`=`stall_pm`=0: `ir`<=mem[0], `pc`<=1.
- LD1 sequence (`ir`=LD1, `pc`=p):
  - c0: stall=1, everything holds.
  - c1: stall=0, stall_pm=1, so `ir`<=NOP and `pc`=p.
  - c2: `ir`<=mem[p], `pc`<=p+1.
- JUMP sequence (`ir`=JUMP, `pc`=p, target T):
  - c0: stall=1, latch T, go to JUMP_WAIT.
  - c1: stall=1, stall_pm=1, hold.
  - c2: stall=0, stall_pm=1, so `ir`<=NOP, `pc`<=T, go to RUN.
  - c3: `ir`<=mem[T], `pc`<=T+1.
- HLT: the edge with `stall`=1 and `op`==HLT sets `halted`=1 on that same edge's update, so `halted` is visible the next cycle.
- All outputs are registered except `pm_addr` (a wire from `pc`) and `op` (a wire from `ir`).

## Test plan
- Reset then free run with mem[i]=i+0x100 and no stalls. Required:
  - `pc` reads 1,2,3…
  - `ir` reads 0x100,0x101… one cycle behind.
  - `pc` wraps 0xFF->0x00 with AW=8.
- LD1 at address 5 (`pc`=6). Required:
  - `ir`=LD1 for 2 cycles, then NOP for 1 cycle, then mem[6].
  - `stall_cnt`=1.
  - `proto_err`=0.
- JUMP at `pc`=0x11 with `jump_target`=0x40 on c0. Change `jump_target` to 0x77 on c1. Required:
  - `pc`=0x40 after c2 (no relatch).
  - `ir`=mem[0x40] after c3.
  - `stall_cnt`=2.
- HLT fetched. Required:
  - `halted`=1 and `pc`/`ir` frozen for 20 cycles.
  - `stall_cnt`=20.
  - Pulse reset low for one edge: all outputs return to reset values and fetch resumes at 0.
- Drive `stall_pm`=1 with no prior `stall`. Required:
  - `proto_err`=1 next cycle and it stays set.
  - `ir`<=NOP on that cycle.
  - Reset clears `proto_err`.
- Assert reset low during JUMP_WAIT (c1). Required: state RUN, `pc`=0, and no jump is taken afterward.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns PC and IR, freezes on stall, inserts a NOP
// bubble on the delayed program-memory gate, redirects on jumps and latches halt.
module fetch_ctrl #(
   parameter int AW    = 8,
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             stall_pm,
   input  logic [AW-1:0]    jump_target,
   input  logic [DW-1:0]    pm_data,
   output logic [AW-1:0]    pm_addr,
   output logic [DW-1:0]    ir,
   output logic [0:5]       op,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             proto_err
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      JUMP_WAIT = 2'd1,
      HALTED    = 2'd2
   } state_t;

   localparam logic [5:0]       OP_HLT  = 6'b010001;
   localparam logic [3:0]       OP_JUMP = 4'b0111;
   localparam logic [AW-1:0]    PC_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   function automatic logic is_halt(input logic [0:5] opc);
      return (opc == OP_HLT);
   endfunction

   function automatic logic is_jump(input logic [0:5] opc);
      return (opc[0:3] == OP_JUMP);
   endfunction

   state_t           state_q, state_d;
   logic [AW-1:0]    pc_q, pc_d;
   logic [DW-1:0]    ir_q, ir_d;
   logic [AW-1:0]    tgt_q, tgt_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             shadow_q, shadow_d;
   logic             perr_q, perr_d;

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= RUN;
         pc_q     <= {AW{1'b0}};
         ir_q     <= {DW{1'b0}};
         tgt_q    <= {AW{1'b0}};
         halted_q <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         shadow_q <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         tgt_q    <= tgt_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         perr_q   <= perr_d;
      end
   end

   // Next-state logic; HLT outranks JUMP while stalled
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (stall) begin
               if (is_halt(op)) begin
                  state_d = HALTED;
               end else if (is_jump(op)) begin
                  state_d = JUMP_WAIT;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = RUN;
            end
         end
         JUMP_WAIT: begin
            if (stall) begin
               if (is_halt(op)) begin
                  state_d = HALTED;
               end else begin
                  state_d = JUMP_WAIT;
               end
            end else begin
               state_d = RUN;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // PC/IR update, jump-target capture, stall counter and protocol check
   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      tgt_d = tgt_q;
      case (state_q)
         RUN: begin
            if (stall) begin
               if (is_jump(op)) begin
                  tgt_d = jump_target;
               end else begin
                  tgt_d = tgt_q;
               end
            end else if (stall_pm) begin
               ir_d = {DW{1'b0}};
            end else begin
               ir_d = pm_data;
               pc_d = pc_q + PC_ONE;
            end
         end
         JUMP_WAIT: begin
            if (stall) begin
               pc_d = pc_q;
            end else if (stall_pm) begin
               ir_d = {DW{1'b0}};
               pc_d = tgt_q;
            end else begin
               ir_d = pm_data;
               pc_d = tgt_q + PC_ONE;
            end
         end
         HALTED:  pc_d = pc_q;
         default: pc_d = pc_q;
      endcase

      halted_d = (state_d == HALTED);

      if (stall && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end

      shadow_d = stall;
      perr_d   = perr_q | (stall_pm != shadow_q);
   end

   assign pm_addr   = pc_q;
   assign ir        = ir_q;
   assign op        = ir_q[DW-1 -: 6];
   assign halted    = halted_q;
   assign stall_cnt = cnt_q;
   assign proto_err = perr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: acts as stall generator and program memory,
// queues expected outputs per step and compares them after each clock edge.
module tb_fetch_ctrl;

   localparam logic [31:0] LD1  = 32'h5000_0000;
   localparam logic [31:0] JMP  = 32'h7C00_00AA;
   localparam logic [31:0] HLT  = 32'h4400_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        stall_pm;
   logic [7:0]  jump_target;
   logic [31:0] pm_data;
   logic [7:0]  pm_addr;
   logic [31:0] ir;
   logic [0:5]  op;
   logic        halted;
   logic [15:0] stall_cnt;
   logic        proto_err;

   logic [31:0] mem [0:255];

   typedef struct {
      logic [7:0]  pc;
      logic [31:0] ir;
      logic        halt;
      logic [15:0] cnt;
      logic        perr;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt;
   logic        exp_perr;
   string       phase;

   always #5 clk = ~clk;

   assign pm_data = mem[pm_addr];

   fetch_ctrl #(.AW(8), .DW(32), .CNT_W(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .stall_pm    (stall_pm),
      .jump_target (jump_target),
      .pm_data     (pm_data),
      .pm_addr     (pm_addr),
      .ir          (ir),
      .op          (op),
      .halted      (halted),
      .stall_cnt   (stall_cnt),
      .proto_err   (proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, expv);
      end
   endtask

   // One clock: drive inputs, queue expectation, compare after the edge
   task automatic step(input logic rst, input logic s, input logic spm,
                       input logic [7:0] jt, input logic [7:0] epc,
                       input logic [31:0] eir, input logic ehalt);
      exp_t e;
      reset       = rst;
      stall       = s;
      stall_pm    = spm;
      jump_target = jt;
      if (!rst) begin
         exp_cnt  = 16'd0;
         exp_perr = 1'b0;
      end else if (s && exp_cnt != 16'hFFFF) begin
         exp_cnt = exp_cnt + 16'd1;
      end
      e.pc   = epc;
      e.ir   = eir;
      e.halt = ehalt;
      e.cnt  = exp_cnt;
      e.perr = exp_perr;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pc",        {24'd0, pm_addr},   {24'd0, e.pc});
      chk("ir",        ir,                 e.ir);
      chk("op",        {26'd0, op},        {26'd0, e.ir[31:26]});
      chk("halted",    {31'd0, halted},    {31'd0, e.halt});
      chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
      chk("proto_err", {31'd0, proto_err}, {31'd0, e.perr});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h100 + 32'(i);
      exp_cnt  = 16'd0;
      exp_perr = 1'b0;

      phase = "reset";
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0);

      phase = "free_run";
      for (int k = 1; k <= 260; k++)
         step(1'b1, 1'b0, 1'b0, 8'h00, 8'(k), 32'h100 + 32'((k - 1) % 256), 1'b0);

      mem[8'h05] = LD1;
      mem[8'h11] = JMP;
      mem[8'h43] = HLT;
      phase = "reset2";
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0);

      phase = "ld1";
      for (int k = 1; k <= 5; k++)
         step(1'b1, 1'b0, 1'b0, 8'h00, 8'(k), 32'h100 + 32'(k - 1), 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h06, LD1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h00, 8'h06, LD1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h00, 8'h06, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h07, 32'h106, 1'b0);
      chk("ld1_cnt", {16'd0, stall_cnt}, 32'd1);

      phase = "jump";
      for (int k = 8; k <= 17; k++)
         step(1'b1, 1'b0, 1'b0, 8'h00, 8'(k), 32'h100 + 32'(k - 1), 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h12, JMP, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h40, 8'h12, JMP, 1'b0);
      step(1'b1, 1'b1, 1'b1, 8'h77, 8'h12, JMP, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h77, 8'h40, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h77, 8'h41, 32'h140, 1'b0);
      chk("jump_cnt", {16'd0, stall_cnt}, 32'd3);

      phase = "halt";
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h42, 32'h141, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h43, 32'h142, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h44, HLT, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h00, 8'h44, HLT, 1'b1);
      for (int k = 0; k < 19; k++)
         step(1'b1, 1'b1, 1'b1, 8'h00, 8'h44, HLT, 1'b1);
      chk("halt_cnt", {16'd0, stall_cnt}, 32'd23);
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 32'h100, 1'b0);

      phase = "proto";
      exp_perr = 1'b1;
      step(1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 32'h101, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 32'h102, 1'b0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0, 1'b0);

      phase = "reset_in_jump_wait";
      for (int k = 1; k <= 18; k++)
         step(1'b1, 1'b0, 1'b0, 8'h00, 8'(k), mem[k - 1], 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h40, 8'h12, JMP, 1'b0);
      step(1'b0, 1'b1, 1'b1, 8'h77, 8'h00, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 32'h100, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 32'h101, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 32'h102, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
